// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station: entry layout, issue bundle and CDB wake helper.
package alu_rs_pkg;

    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned TAG_W_DEF = 4;

    typedef logic [TAG_W_DEF-1:0] tag_t;

    typedef struct packed {
        logic       rdy;
        tag_t       tag;
        logic [7:0] val;
    } rs_src_t;

    typedef struct packed {
        logic             valid;
        logic [7:0]       operand;
        logic [7:0]       flags;
        logic [7:0]       wbs;
        tag_t             robid;
        rs_src_t [1:0]    src;
    } rs_entry_t;

    typedef struct packed {
        logic             input_transmit;
        logic [7:0]       operand;
        logic [1:0][7:0]  depvals;
        logic [7:0]       wbs;
        logic [7:0]       flags;
        tag_t             robid;
    } rs_issue_t;

    // A waiting source captures the broadcast value when its producer tag matches.
    function automatic rs_src_t wake_src(input rs_src_t s, input logic bc_valid,
                                         input tag_t bc_id, input logic [7:0] bc_val);
        rs_src_t r;
        r = s;
        if (!s.rdy && bc_valid && (s.tag == bc_id)) begin
            r.rdy = 1'b1;
            r.val = bc_val;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-index-ready priority selector (rs_pick): index 0 is the oldest entry.
module alu_rs_pick #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] sel_oh,
    output logic [IDX_W-1:0] sel_idx,
    output logic             any_ready
);

    always_comb begin
        sel_oh    = '0;
        sel_idx   = '0;
        any_ready = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                sel_idx   = IDX_W'(i);
                any_ready = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: collapsing age-ordered queue with CDB wakeup, issuing the oldest
// ready micro-op to the ALU FU. Struct tag widths come from alu_rs_pkg, so TAG_W tracks TAG_W_DEF.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   disp_valid,
    output logic                   disp_ready,
    input  logic [7:0]             disp_operand,
    input  logic [7:0]             disp_flags,
    input  logic [7:0]             disp_wbs,
    input  logic [TAG_W-1:0]       disp_robid,
    input  logic [1:0]             disp_dep_rdy,
    input  logic [1:0][TAG_W-1:0]  disp_dep_tag,
    input  logic [1:0][7:0]        disp_dep_val,
    input  logic                   cdb_valid,
    input  logic [TAG_W-1:0]       cdb_id,
    input  logic [7:0]             cdb_val,
    input  logic                   fu_busy,
    output logic                   input_transmit,
    output logic [7:0]             operand,
    output logic [1:0][7:0]        depvals,
    output logic [7:0]             wbs,
    output logic [7:0]             flags,
    output logic [TAG_W-1:0]       robid,
    output logic [OCC_W-1:0]       occupancy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    rs_entry_t        entries_q [DEPTH];
    rs_entry_t        entries_d [DEPTH];
    rs_entry_t        woken     [DEPTH];
    rs_entry_t        new_entry;
    rs_entry_t        sel_entry;
    rs_issue_t        issue_q, issue_d;
    logic [OCC_W-1:0] occ_q, occ_d, occ_mid;
    logic [DEPTH-1:0] ready, sel_oh;
    logic [IDX_W-1:0] sel_idx;
    logic             any_ready, do_issue, accept;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = entries_q[i].valid & entries_q[i].src[0].rdy & entries_q[i].src[1].rdy;
        end
    end

    alu_rs_pick #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .ready     (ready),
        .sel_oh    (sel_oh),
        .sel_idx   (sel_idx),
        .any_ready (any_ready)
    );

    assign disp_ready = (occ_q < OCC_W'(DEPTH));

    always_comb begin
        do_issue = any_ready & ~fu_busy;
        accept   = disp_valid & disp_ready;

        new_entry.valid   = 1'b1;
        new_entry.operand = disp_operand;
        new_entry.flags   = disp_flags;
        new_entry.wbs     = disp_wbs;
        new_entry.robid   = disp_robid;
        for (int s = 0; s < 2; s++) begin
            new_entry.src[s].rdy = disp_dep_rdy[s];
            new_entry.src[s].tag = disp_dep_tag[s];
            new_entry.src[s].val = disp_dep_val[s];
            new_entry.src[s]     = wake_src(new_entry.src[s], cdb_valid, cdb_id, cdb_val);
        end

        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = entries_q[i];
            if (entries_q[i].valid) begin
                for (int s = 0; s < 2; s++) begin
                    woken[i].src[s] = wake_src(entries_q[i].src[s], cdb_valid, cdb_id, cdb_val);
                end
            end
        end

        // Collapse over the issued slot first, then append at the post-collapse tail.
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (do_issue && (IDX_W'(i) >= sel_idx)) begin
                entries_d[i] = woken[i + 1];
            end else begin
                entries_d[i] = woken[i];
            end
        end
        entries_d[DEPTH-1] = do_issue ? '0 : woken[DEPTH-1];

        occ_mid = occ_q - OCC_W'(do_issue);
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (occ_mid == OCC_W'(i))) begin
                entries_d[i] = new_entry;
            end
        end
        occ_d = occ_q + OCC_W'(accept) - OCC_W'(do_issue);

        sel_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                sel_entry = entries_q[i];
            end
        end

        issue_d                = issue_q;
        issue_d.input_transmit = do_issue;
        if (do_issue) begin
            issue_d.operand    = sel_entry.operand;
            issue_d.depvals[0] = sel_entry.src[0].val;
            issue_d.depvals[1] = sel_entry.src[1].val;
            issue_d.wbs        = sel_entry.wbs;
            issue_d.flags      = sel_entry.flags;
            issue_d.robid      = sel_entry.robid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            occ_q   <= '0;
            issue_q <= '0;
        end else begin
            entries_q <= entries_d;
            occ_q     <= occ_d;
            issue_q   <= issue_d;
        end
    end

    assign input_transmit = issue_q.input_transmit;
    assign operand        = issue_q.operand;
    assign depvals        = issue_q.depvals;
    assign wbs            = issue_q.wbs;
    assign flags          = issue_q.flags;
    assign robid          = issue_q.robid;
    assign occupancy      = occ_q;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios plus randomized traffic against a queue-based model.
module tb_alu_rs;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic                  clk = 1'b0;
    logic                  rst, flush, disp_valid, disp_ready;
    logic [7:0]            disp_operand, disp_flags, disp_wbs;
    logic [TAG_W-1:0]      disp_robid;
    logic [1:0]            disp_dep_rdy;
    logic [1:0][TAG_W-1:0] disp_dep_tag;
    logic [1:0][7:0]       disp_dep_val;
    logic                  cdb_valid;
    logic [TAG_W-1:0]      cdb_id;
    logic [7:0]            cdb_val;
    logic                  fu_busy;
    logic                  input_transmit;
    logic [7:0]            operand, wbs, flags;
    logic [1:0][7:0]       depvals;
    logic [TAG_W-1:0]      robid;
    logic [OCC_W-1:0]      occupancy;

    int n_checks = 0;
    int n_pass   = 0;

    alu_rs #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_operand   (disp_operand),
        .disp_flags     (disp_flags),
        .disp_wbs       (disp_wbs),
        .disp_robid     (disp_robid),
        .disp_dep_rdy   (disp_dep_rdy),
        .disp_dep_tag   (disp_dep_tag),
        .disp_dep_val   (disp_dep_val),
        .cdb_valid      (cdb_valid),
        .cdb_id         (cdb_id),
        .cdb_val        (cdb_val),
        .fu_busy        (fu_busy),
        .input_transmit (input_transmit),
        .operand        (operand),
        .depvals        (depvals),
        .wbs            (wbs),
        .flags          (flags),
        .robid          (robid),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    // Reference model: a list of waiting micro-ops in arrival order.
    typedef struct {
        logic [7:0]            op, fl, wb;
        logic [TAG_W-1:0]      rid;
        logic [1:0]            rdy;
        logic [1:0][TAG_W-1:0] tag;
        logic [1:0][7:0]       val;
    } m_ent_t;

    m_ent_t           m_q[$];
    logic             m_it;
    logic [7:0]       m_op, m_wbs, m_fl;
    logic [1:0][7:0]  m_dv;
    logic [TAG_W-1:0] m_rid;

    function automatic void model_edge();
        int     pick;
        bit     acc;
        m_ent_t e;
        if (rst || flush) begin
            m_q.delete();
            m_it = 0; m_op = 0; m_dv = '0; m_wbs = 0; m_fl = 0; m_rid = 0;
            return;
        end
        acc  = disp_valid && (m_q.size() < DEPTH);
        pick = -1;
        for (int i = 0; i < m_q.size(); i++) begin
            if (pick < 0 && m_q[i].rdy == 2'b11) pick = i;
        end
        m_it = 0;
        if (!fu_busy && pick >= 0) begin
            m_it  = 1;
            m_op  = m_q[pick].op;
            m_dv  = m_q[pick].val;
            m_wbs = m_q[pick].wb;
            m_fl  = m_q[pick].fl;
            m_rid = m_q[pick].rid;
            m_q.delete(pick);
        end
        for (int i = 0; i < m_q.size(); i++) begin
            for (int s = 0; s < 2; s++) begin
                if (!m_q[i].rdy[s] && cdb_valid && m_q[i].tag[s] == cdb_id) begin
                    m_q[i].rdy[s] = 1'b1;
                    m_q[i].val[s] = cdb_val;
                end
            end
        end
        if (acc) begin
            e.op = disp_operand; e.fl = disp_flags; e.wb = disp_wbs; e.rid = disp_robid;
            e.rdy = disp_dep_rdy; e.tag = disp_dep_tag; e.val = disp_dep_val;
            for (int s = 0; s < 2; s++) begin
                if (!e.rdy[s] && cdb_valid && e.tag[s] == cdb_id) begin
                    e.rdy[s] = 1'b1;
                    e.val[s] = cdb_val;
                end
            end
            m_q.push_back(e);
        end
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; disp_valid = 0; cdb_valid = 0; cdb_id = 0; cdb_val = 0;
    endtask

    task automatic set_disp(input logic [TAG_W-1:0] rid, input logic [7:0] op,
                            input logic [1:0] rdy, input logic [TAG_W-1:0] t0,
                            input logic [TAG_W-1:0] t1, input logic [7:0] v0,
                            input logic [7:0] v1);
        disp_valid = 1; disp_robid = rid; disp_operand = op;
        disp_flags = op ^ 8'h5A; disp_wbs = op + 8'h10;
        disp_dep_rdy = rdy; disp_dep_tag[0] = t0; disp_dep_tag[1] = t1;
        disp_dep_val[0] = v0; disp_dep_val[1] = v1;
    endtask

    task automatic test_reset();
        idle(); fu_busy = 0; rst = 1;
        set_disp(4'h1, 8'h33, 2'b11, 0, 0, 8'h01, 8'h02);
        step(); step();
        idle();
        n_checks++;
        if (input_transmit !== 1'b0) $display("FAIL reset_it: got %0b want 0", input_transmit);
        else n_pass++;
        n_checks++;
        if (occupancy !== '0) $display("FAIL reset_occ: got %0d want 0", occupancy);
        else n_pass++;
        n_checks++;
        if (disp_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", disp_ready);
        else n_pass++;
        n_checks++;
        if ({operand, depvals, wbs, flags, robid} !== '0)
            $display("FAIL reset_payload: got %h want 0", {operand, depvals, wbs, flags, robid});
        else n_pass++;
    endtask

    task automatic test_issue_basic();
        set_disp(4'd2, 8'h01, 2'b11, 0, 0, 8'h05, 8'h03);
        step();
        idle();
        n_checks++;
        if (occupancy !== 3'd1 || input_transmit !== 1'b0)
            $display("FAIL basic_enter: got occ=%0d it=%0b want occ=1 it=0", occupancy, input_transmit);
        else n_pass++;
        step();
        n_checks++;
        if (input_transmit !== 1'b1 || depvals !== {8'h03, 8'h05} || robid !== 4'd2 ||
            operand !== 8'h01 || occupancy !== 3'd0)
            $display("FAIL basic_issue: got it=%0b dv=%h rid=%0d op=%h occ=%0d want 1 0305 2 01 0",
                     input_transmit, depvals, robid, operand, occupancy);
        else n_pass++;
        step();
        n_checks++;
        if (input_transmit !== 1'b0 || robid !== 4'd2)
            $display("FAIL basic_pulse: got it=%0b rid=%0d want it=0 rid=2", input_transmit, robid);
        else n_pass++;
    endtask

    task automatic test_wakeup();
        set_disp(4'd3, 8'h22, 2'b10, 4'd7, 0, 8'h00, 8'h22);
        step();
        idle();
        step(); step();
        n_checks++;
        if (input_transmit !== 1'b0 || occupancy !== 3'd1)
            $display("FAIL wake_wait: got it=%0b occ=%0d want 0 1", input_transmit, occupancy);
        else n_pass++;
        cdb_valid = 1; cdb_id = 4'd7; cdb_val = 8'hAA;
        step();
        idle();
        n_checks++;
        if (input_transmit !== 1'b0)
            $display("FAIL wake_same_cycle: got it=%0b want 0", input_transmit);
        else n_pass++;
        step();
        n_checks++;
        if (input_transmit !== 1'b1 || depvals[0] !== 8'hAA || robid !== 4'd3)
            $display("FAIL wake_issue: got it=%0b dv0=%h rid=%0d want 1 aa 3",
                     input_transmit, depvals[0], robid);
        else n_pass++;
    endtask

    task automatic test_bypass();
        set_disp(4'd4, 8'h44, 2'b01, 0, 4'd5, 8'h44, 8'h00);
        cdb_valid = 1; cdb_id = 4'd5; cdb_val = 8'h11;
        step();
        idle();
        step();
        n_checks++;
        if (input_transmit !== 1'b1 || depvals[1] !== 8'h11 || robid !== 4'd4)
            $display("FAIL bypass_issue: got it=%0b dv1=%h rid=%0d want 1 11 4",
                     input_transmit, depvals[1], robid);
        else n_pass++;
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            set_disp(4'(k), 8'(8'h80 + k), 2'b10, 4'd9, 0, 8'h00, 8'(k));
            step();
        end
        n_checks++;
        if (disp_ready !== 1'b0 || occupancy !== 3'd4)
            $display("FAIL full_ready: got rdy=%0b occ=%0d want 0 4", disp_ready, occupancy);
        else n_pass++;
        set_disp(4'hF, 8'hFF, 2'b11, 0, 0, 8'h01, 8'h01);
        step();
        n_checks++;
        if (occupancy !== 3'd4 || input_transmit !== 1'b0)
            $display("FAIL full_drop: got occ=%0d it=%0b want 4 0", occupancy, input_transmit);
        else n_pass++;
        idle();
        cdb_valid = 1; cdb_id = 4'd9; cdb_val = 8'h99;
        step();
        idle();
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (input_transmit !== 1'b1 || robid !== 4'(k) || depvals[0] !== 8'h99)
                $display("FAIL full_order%0d: got it=%0b rid=%0d dv0=%h want 1 %0d 99",
                         k, input_transmit, robid, depvals[0], k);
            else n_pass++;
        end
        step();
        n_checks++;
        if (input_transmit !== 1'b0 || occupancy !== 3'd0)
            $display("FAIL full_drain: got it=%0b occ=%0d want 0 0", input_transmit, occupancy);
        else n_pass++;
    endtask

    task automatic test_busy();
        fu_busy = 1;
        set_disp(4'd6, 8'h06, 2'b11, 0, 0, 8'h16, 8'h26); step();
        set_disp(4'd7, 8'h07, 2'b11, 0, 0, 8'h17, 8'h27); step();
        idle();
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (input_transmit !== 1'b0 || occupancy !== 3'd2)
                $display("FAIL busy_hold%0d: got it=%0b occ=%0d want 0 2",
                         k, input_transmit, occupancy);
            else n_pass++;
        end
        fu_busy = 0;
        step();
        n_checks++;
        if (input_transmit !== 1'b1 || robid !== 4'd6)
            $display("FAIL busy_first: got it=%0b rid=%0d want 1 6", input_transmit, robid);
        else n_pass++;
        step();
        n_checks++;
        if (input_transmit !== 1'b1 || robid !== 4'd7 || depvals !== {8'h27, 8'h17})
            $display("FAIL busy_second: got it=%0b rid=%0d dv=%h want 1 7 2717",
                     input_transmit, robid, depvals);
        else n_pass++;
        step();
    endtask

    task automatic test_flush();
        fu_busy = 1;
        for (int k = 0; k < 3; k++) begin
            set_disp(4'(8 + k), 8'(8'h40 + k), 2'b11, 0, 0, 8'h0C, 8'h0D);
            step();
        end
        set_disp(4'd11, 8'h4B, 2'b11, 0, 0, 8'h0E, 8'h0F);
        flush = 1;
        step();
        idle();
        n_checks++;
        if (occupancy !== 3'd0 || disp_ready !== 1'b1 || input_transmit !== 1'b0 || robid !== 4'd0)
            $display("FAIL flush_state: got occ=%0d rdy=%0b it=%0b rid=%0d want 0 1 0 0",
                     occupancy, disp_ready, input_transmit, robid);
        else n_pass++;
        fu_busy = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (input_transmit !== 1'b0 || occupancy !== 3'd0)
                $display("FAIL flush_noissue%0d: got it=%0b occ=%0d want 0 0",
                         k, input_transmit, occupancy);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [OCC_W-1:0] exp_occ;
        logic             exp_rdy;
        for (int c = 0; c < 600; c++) begin
            idle();
            fu_busy = ($urandom_range(0, 3) == 0);
            flush   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 1) == 1)
                set_disp(4'($urandom), 8'($urandom), 2'($urandom), 4'($urandom_range(0, 3)),
                         4'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                cdb_valid = 1; cdb_id = 4'($urandom_range(0, 3)); cdb_val = 8'($urandom);
            end
            step();
            exp_occ = OCC_W'(m_q.size());
            exp_rdy = (m_q.size() < DEPTH);
            n_checks++;
            if ({input_transmit, operand, depvals, wbs, flags, robid, occupancy, disp_ready} !==
                {m_it, m_op, m_dv, m_wbs, m_fl, m_rid, exp_occ, exp_rdy})
                $display("FAIL rand_cycle%0d: got it=%0b op=%h dv=%h wbs=%h fl=%h rid=%0d occ=%0d rdy=%0b want it=%0b op=%h dv=%h wbs=%h fl=%h rid=%0d occ=%0d rdy=%0b",
                         c, input_transmit, operand, depvals, wbs, flags, robid, occupancy,
                         disp_ready, m_it, m_op, m_dv, m_wbs, m_fl, m_rid, exp_occ, exp_rdy);
            else n_pass++;
        end
    endtask

    initial begin
        idle();
        fu_busy = 0;
        set_disp(0, 0, 2'b00, 0, 0, 0, 0);
        disp_valid = 0;
        test_reset();
        test_issue_basic();
        test_wakeup();
        test_bypass();
        test_full();
        test_busy();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station for the ALU functional unit. Directly upstream of alufu.
- Buffers dispatched ALU micro-ops until both source operands are valid.
- Snoops the CDB to wake waiting operands.
- Issues the oldest ready entry to the ALU FU, in the exact bundle alufu consumes (input_transmit, operand, depvals, wbs, flags, robid).

Parameters:
- DEPTH, 4, number of RS entries (2..8).
- TAG_W, 4, ROB-id / CDB tag width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  squash all entries (same effect as rst on state)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  entry available (not full)
- disp_operand  in  8  opcode/immediate byte
- disp_flags  in  8  micro-op flags, passed through
- disp_wbs  in  8  writeback selector, passed through
- disp_robid  in  TAG_W  ROB id of the micro-op
- disp_dep_rdy  in  2  per-source: value already valid
- disp_dep_tag  in  2xTAG_W  per-source producer ROB id when not ready
- disp_dep_val  in  2x8  per-source value when ready
- cdb_valid  in  1  CDB broadcast this cycle
- cdb_id  in  TAG_W  broadcast ROB id
- cdb_val  in  8  broadcast value
- fu_busy  in  1  ALU FU cannot accept this cycle
- input_transmit  out  1  one-cycle issue strobe to FU
- operand  out  8  issued operand
- depvals  out  2x8  issued source values
- wbs  out  8  issued wbs
- flags  out  8  issued flags
- robid  out  TAG_W  issued ROB id
- occupancy  out  $clog2(DEPTH+1)  valid entry count

Behaviour:
- Reset/flush (synchronous, active-high):
  - All entries invalid; occupancy=0; disp_ready=1.
  - input_transmit=0; operand, depvals, wbs, flags and robid all 0.
  - flush has priority over a dispatch in the same cycle; that dispatch is dropped.
- Storage: collapsing age-ordered queue. Index 0 is oldest. Each entry holds valid, operand, flags, wbs, robid, and per source {rdy, tag, val}.
- Dispatch:
  - Accepted on an edge where disp_valid & disp_ready.
  - Written at index = occupancy, after collapse from any same-edge issue.
  - disp_ready = (occupancy < DEPTH), computed from registered state only. When full, an issue in the same cycle does not enable a same-cycle accept.
- Dispatch-time bypass: if a source has disp_dep_rdy=0, cdb_valid=1 and cdb_id==disp_dep_tag, the source is stored as ready with cdb_val.
- Immediate ops: the dispatcher sets disp_dep_rdy[1]=1 (val don't-care). The RS makes no decode of flags.
- Wakeup: each cycle, every valid entry source with rdy=0 and tag==cdb_id (cdb_valid=1) captures cdb_val and sets rdy at the edge.
- Select:
  - Ready = valid & both rdy, using registered state. A value woken this edge becomes eligible the following cycle; there is no same-cycle wake-and-issue.
  - Pick the lowest ready index (oldest).
- Issue:
  - If fu_busy=0 and any entry is ready, at the edge:
    - Register the selected entry into the issue outputs.
    - Drive input_transmit=1 for exactly one cycle.
    - Remove the entry; younger entries shift down one index.
  - Otherwise input_transmit=0 and the issue payload outputs hold their last values.
- Latency: an operand-ready dispatch at edge t enters the RS; it issues at edge t+1 with input_transmit high in cycle t+1..t+2, if fu_busy=0 and it is the oldest ready entry.
- Simultaneous events:
  - Dispatch + issue + CDB wakeup on one edge are all applied. The shift happens before the new entry is appended.
  - A CDB wakeup also applies to entries that shift that edge.
- Occupancy: next = occupancy + accept − issue. It never wraps; the accept gating guarantees ≤DEPTH.
- Tags are compared on all TAG_W bits. There is no reserved tag value.

Decomposition:
- Package alu_rs_pkg:
  - rs_src_t {rdy, tag, val}
  - rs_entry_t {valid, operand, flags, wbs, robid, src[2]}
  - issue bundle struct matching the FU input fields
  - DEPTH/TAG_W defaults
- Sub-module rs_pick: combinational lowest-index-ready priority selector, DEPTH in, one-hot plus index plus any_ready out.

Test Plan:
- Reset, then dispatch operand=0x01, both deps ready (0x05, 0x03), robid=2, fu_busy=0 → input_transmit pulses one cycle later with depvals={0x03,0x05}, robid=2; occupancy returns to 0.
- Dispatch robid=3 with src0 waiting on tag 7. Two cycles later, CDB id=7 val=0xAA → input_transmit asserted the cycle after the wakeup edge with depvals[0]=0xAA.
- Dispatch robid=4 with src1 tag 5 in the same cycle as CDB id=5 val=0x11 → entry stored ready; issues next cycle with depvals[1]=0x11 (bypass).
- Fill 4 entries all waiting on tag 9 → disp_ready=0, and a 5th disp_valid is ignored. CDB id=9 → entries issue one per cycle in dispatch order robid 0,1,2,3.
- Hold fu_busy=1 with 2 ready entries for 3 cycles → no input_transmit, occupancy stays 2. Drop fu_busy → oldest issues first.
- With 3 entries valid, assert flush together with disp_valid → next cycle occupancy=0, disp_ready=1, input_transmit=0, and the flushed ops never issue.
